// File: rtl/rx_packet_parser.sv
// Parses a UART RX byte stream: 4-byte header (opcode, reserved, LEN LSB/MSB), then either
// packs arithmetic payload into little-endian 32-bit words or passes echo payload through.
module rx_packet_parser #(
    parameter logic [7:0] OP_ECHO    = 8'hEC,
    parameter logic [7:0] OP_ADD     = 8'hAD,
    parameter logic [7:0] ARITH_MASK = 8'hA0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  s_byte_tdata,
    input  logic        s_byte_tvalid,
    output logic        s_byte_tready,
    output logic        hdr_valid_o,
    input  logic        hdr_ready_i,
    output logic [7:0]  hdr_opcode_o,
    output logic [15:0] hdr_len_o,
    output logic [31:0] m_word_tdata,
    output logic        m_word_tvalid,
    input  logic        m_word_tready,
    output logic        m_word_tlast,
    output logic [7:0]  m_echo_tdata,
    output logic        m_echo_tvalid,
    input  logic        m_echo_tready,
    output logic        m_echo_tlast,
    output logic        err_len_o
);

    typedef enum logic [2:0] {
        StIdle, StRsvd, StLenL, StLenH, StHdr, StAsm, StWout, StEcho
    } state_e;

    state_e      r_state, w_state_next;
    logic [7:0]  r_opcode, w_opcode_next;
    logic [7:0]  r_len_lo, w_len_lo_next;
    logic [15:0] r_remaining, w_remaining_next;
    logic [1:0]  r_byte_idx, w_byte_idx_next;
    logic [31:0] r_word, w_word_next;
    logic        r_err, w_err_next;

    logic        w_byte_tready;
    logic        w_byte_hs;
    logic        w_is_echo;
    logic        w_is_arith;
    logic [15:0] w_len_full;

    assign w_is_echo  = (s_byte_tdata == OP_ECHO);
    assign w_is_arith = (s_byte_tdata[7:4] == ARITH_MASK[7:4]) || (s_byte_tdata == OP_ADD);
    assign w_len_full = {s_byte_tdata, r_len_lo};

    // Echo stalls the source exactly when the echo consumer stalls.
    always_comb begin
        w_byte_tready = 1'b0;
        unique case (r_state)
            StIdle, StRsvd, StLenL, StLenH, StAsm: w_byte_tready = 1'b1;
            StEcho:                                w_byte_tready = m_echo_tready;
            default:                               w_byte_tready = 1'b0;
        endcase
    end

    assign w_byte_hs = s_byte_tvalid && w_byte_tready;

    always_comb begin
        w_state_next     = r_state;
        w_opcode_next    = r_opcode;
        w_len_lo_next    = r_len_lo;
        w_remaining_next = r_remaining;
        w_byte_idx_next  = r_byte_idx;
        w_word_next      = r_word;
        w_err_next       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_byte_hs && (w_is_echo || w_is_arith)) begin
                    w_opcode_next = s_byte_tdata;
                    w_state_next  = StRsvd;
                end
            end
            StRsvd: begin
                if (w_byte_hs) w_state_next = StLenL;
            end
            StLenL: begin
                if (w_byte_hs) begin
                    w_len_lo_next = s_byte_tdata;
                    w_state_next  = StLenH;
                end
            end
            StLenH: begin
                if (w_byte_hs) begin
                    if (w_len_full < 16'd4) begin
                        w_err_next   = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_remaining_next = w_len_full - 16'd4;
                        w_state_next     = StHdr;
                    end
                end
            end
            StHdr: begin
                if (hdr_ready_i) begin
                    if (r_remaining == 16'd0) begin
                        w_state_next = StIdle;
                    end else if (r_opcode == OP_ECHO) begin
                        w_state_next = StEcho;
                    end else begin
                        w_byte_idx_next = 2'd0;
                        w_word_next     = 32'd0;
                        w_state_next    = StAsm;
                    end
                end
            end
            StAsm: begin
                if (w_byte_hs) begin
                    w_word_next[{r_byte_idx, 3'b000} +: 8] = s_byte_tdata;
                    w_remaining_next = r_remaining - 16'd1;
                    w_byte_idx_next  = r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3 || r_remaining == 16'd1) w_state_next = StWout;
                end
            end
            StWout: begin
                if (m_word_tready) begin
                    if (r_remaining == 16'd0) begin
                        w_state_next = StIdle;
                    end else begin
                        w_byte_idx_next = 2'd0;
                        w_word_next     = 32'd0;
                        w_state_next    = StAsm;
                    end
                end
            end
            StEcho: begin
                if (w_byte_hs) begin
                    w_remaining_next = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_opcode    <= 8'd0;
            r_len_lo    <= 8'd0;
            r_remaining <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_word      <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_opcode    <= w_opcode_next;
            r_len_lo    <= w_len_lo_next;
            r_remaining <= w_remaining_next;
            r_byte_idx  <= w_byte_idx_next;
            r_word      <= w_word_next;
            r_err       <= w_err_next;
        end
    end

    assign s_byte_tready = w_byte_tready;
    assign hdr_valid_o   = (r_state == StHdr);
    assign hdr_opcode_o  = r_opcode;
    assign hdr_len_o     = r_remaining;
    assign m_word_tdata  = r_word;
    assign m_word_tvalid = (r_state == StWout);
    assign m_word_tlast  = (r_state == StWout) && (r_remaining == 16'd0);
    assign m_echo_tvalid = (r_state == StEcho) && s_byte_tvalid;
    assign m_echo_tdata  = (r_state == StEcho) ? s_byte_tdata : 8'd0;
    assign m_echo_tlast  = (r_state == StEcho) && (r_remaining == 16'd1);
    assign err_len_o     = r_err;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Scoreboard bench for rx_packet_parser: stimulus pushes expected header/word/echo records,
// a negedge monitor pops and compares them on each output handshake.
module tb_rx_packet_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_byte_tdata;
    logic        s_byte_tvalid;
    logic        s_byte_tready;
    logic        hdr_valid_o;
    logic        hdr_ready_i;
    logic [7:0]  hdr_opcode_o;
    logic [15:0] hdr_len_o;
    logic [31:0] m_word_tdata;
    logic        m_word_tvalid;
    logic        m_word_tready;
    logic        m_word_tlast;
    logic [7:0]  m_echo_tdata;
    logic        m_echo_tvalid;
    logic        m_echo_tready;
    logic        m_echo_tlast;
    logic        err_len_o;

    always #5 clk = ~clk;

    rx_packet_parser dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .s_byte_tdata  (s_byte_tdata),
        .s_byte_tvalid (s_byte_tvalid),
        .s_byte_tready (s_byte_tready),
        .hdr_valid_o   (hdr_valid_o),
        .hdr_ready_i   (hdr_ready_i),
        .hdr_opcode_o  (hdr_opcode_o),
        .hdr_len_o     (hdr_len_o),
        .m_word_tdata  (m_word_tdata),
        .m_word_tvalid (m_word_tvalid),
        .m_word_tready (m_word_tready),
        .m_word_tlast  (m_word_tlast),
        .m_echo_tdata  (m_echo_tdata),
        .m_echo_tvalid (m_echo_tvalid),
        .m_echo_tready (m_echo_tready),
        .m_echo_tlast  (m_echo_tlast),
        .err_len_o     (err_len_o)
    );

    int total = 0;
    int bad   = 0;
    int err_exp  = 0;
    int err_seen = 0;

    logic [23:0] hdr_q[$];   // {opcode, len}
    logic [32:0] word_q[$];  // {tlast, data}
    logic [8:0]  echo_q[$];  // {tlast, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample away from the rising edge.
    initial begin
        logic        p_wv, p_wr, p_hv, p_hr, p_err;
        logic [32:0] p_wd;
        logic [23:0] p_hd;
        logic [63:0] e;
        p_wv = 0; p_wr = 0; p_hv = 0; p_hr = 0; p_err = 0; p_wd = '0; p_hd = '0;
        forever begin
            @(negedge clk);
            if (hdr_valid_o && hdr_ready_i) begin
                if (hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
                else begin
                    e = 64'(hdr_q.pop_front());
                    check("hdr", {40'd0, hdr_opcode_o, hdr_len_o}, e);
                end
            end
            if (m_word_tvalid && m_word_tready) begin
                if (word_q.size() == 0) check("word_unexpected", 1, 0);
                else begin
                    e = 64'(word_q.pop_front());
                    check("word", {31'd0, m_word_tlast, m_word_tdata}, e);
                end
            end
            if (m_echo_tvalid && m_echo_tready) begin
                if (echo_q.size() == 0) check("echo_unexpected", 1, 0);
                else begin
                    e = 64'(echo_q.pop_front());
                    check("echo", {55'd0, m_echo_tlast, m_echo_tdata}, e);
                end
            end
            if (m_word_tvalid && m_echo_tvalid) check("word_echo_exclusive", 1, 0);
            if (p_wv && !p_wr && m_word_tvalid)
                check("word_stable", {31'd0, m_word_tlast, m_word_tdata}, {31'd0, p_wd});
            if (p_hv && !p_hr && hdr_valid_o)
                check("hdr_stable", {40'd0, hdr_opcode_o, hdr_len_o}, {40'd0, p_hd});
            if (err_len_o) begin
                err_seen++;
                if (p_err) check("err_one_cycle", 1, 0);
            end
            p_err = err_len_o;
            p_wv = m_word_tvalid; p_wr = m_word_tready; p_wd = {m_word_tlast, m_word_tdata};
            p_hv = hdr_valid_o;   p_hr = hdr_ready_i;   p_hd = {hdr_opcode_o, hdr_len_o};
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the last byte's handshake.
    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[k]) begin
            bit done;
            done = 0;
            s_byte_tdata  = bytes[k];
            s_byte_tvalid = 1'b1;
            for (int t = 0; t < 200 && !done; t++) begin
                @(negedge clk);
                if (s_byte_tready) begin
                    @(posedge clk);
                    #1;
                    done = 1;
                end
            end
            s_byte_tvalid = 1'b0;
            if (!done) begin
                check("byte_accept_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic expect_t1();
        hdr_q.push_back({8'hAD, 16'd8});
        word_q.push_back({1'b0, 32'h04030201});
        word_q.push_back({1'b1, 32'h08070605});
    endtask

    task automatic expect_t2();
        hdr_q.push_back({8'hEC, 16'd3});
        echo_q.push_back({1'b0, 8'h41});
        echo_q.push_back({1'b0, 8'h42});
        echo_q.push_back({1'b1, 8'h43});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_byte_tdata = 8'd0; s_byte_tvalid = 1'b0;
        hdr_ready_i = 1'b1; m_word_tready = 1'b1; m_echo_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_valid", 64'(hdr_valid_o), 0);
        check("rst_word_valid", 64'(m_word_tvalid), 0);
        check("rst_word_last", 64'(m_word_tlast), 0);
        check("rst_echo_valid", 64'(m_echo_tvalid), 0);
        check("rst_err", 64'(err_len_o), 0);
        check("rst_word_data", 64'(m_word_tdata), 0);
        check("rst_hdr_len", 64'(hdr_len_o), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 ADD
        expect_t1();
        send_bytes('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                     8'h05, 8'h06, 8'h07, 8'h08});
        settle();
        check("t1_idle_tready", 64'(s_byte_tready), 1);

        // T2 ECHO
        expect_t2();
        send_bytes('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        settle();

        // T3 junk byte then short arithmetic packet
        hdr_q.push_back({8'hAD, 16'd2});
        word_q.push_back({1'b1, 32'h00002211});
        send_bytes('{8'h55, 8'hAD, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22});
        settle();

        // T4 bad length, then zero-payload packet
        err_exp++;
        send_bytes('{8'hAD, 8'h00, 8'h03, 8'h00});
        settle();
        check("t4_err_count", 64'(err_seen), 64'(err_exp));
        hdr_q.push_back({8'hAD, 16'd0});
        send_bytes('{8'hAD, 8'h00, 8'h04, 8'h00});
        settle();
        check("t4_idle_tready", 64'(s_byte_tready), 1);

        // T5 backpressure on header and first word
        hdr_ready_i = 1'b0;
        m_word_tready = 1'b0;
        expect_t1();
        fork
            send_bytes('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                         8'h05, 8'h06, 8'h07, 8'h08});
            begin
                for (int i = 0; i < 100 && !hdr_valid_o; i++) @(negedge clk);
                check("t5_hdr_seen", 64'(hdr_valid_o), 1);
                repeat (4) @(posedge clk);
                #1 hdr_ready_i = 1'b1;
                for (int i = 0; i < 100 && !m_word_tvalid; i++) @(negedge clk);
                check("t5_word_seen", 64'(m_word_tvalid), 1);
                repeat (5) begin
                    @(negedge clk);
                    check("t5_stall_tready", 64'(s_byte_tready), 0);
                end
                @(posedge clk);
                #1 m_word_tready = 1'b1;
            end
        join
        settle();

        // T6 reset mid-packet, then a fresh echo packet
        hdr_q.push_back({8'hAD, 16'd8});
        send_bytes('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02});
        rst_n = 1'b0;
        #1;
        check("t6_hdr_valid", 64'(hdr_valid_o), 0);
        check("t6_word_valid", 64'(m_word_tvalid), 0);
        check("t6_echo_valid", 64'(m_echo_tvalid), 0);
        check("t6_word_data", 64'(m_word_tdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_t2();
        send_bytes('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
        settle();

        check("hdr_q_drained", 64'(hdr_q.size()), 0);
        check("word_q_drained", 64'(word_q.size()), 0);
        check("echo_q_drained", 64'(echo_q.size()), 0);
        check("err_total", 64'(err_seen), 64'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
